// File: rtl/turn_lamp_driver_if.sv
// Lamp driver bus: ignition/turn/gear requests in, lamp drives and flash count out.
// HAZARD_EN adds the _hazard request line.
interface turn_lamp_driver_if;
  logic       _switch;
  logic [1:0] _turnState;
  logic [1:0] _gearState;
`ifdef HAZARD_EN
  logic       _hazard;
`endif
  logic       _leftLamp;
  logic       _rightLamp;
  logic       _reverseLamp;
  logic [7:0] _flashCount;

`ifdef HAZARD_EN
  modport master (output _switch, _turnState, _gearState, _hazard,
                  input  _leftLamp, _rightLamp, _reverseLamp, _flashCount);
  modport slave  (input  _switch, _turnState, _gearState, _hazard,
                  output _leftLamp, _rightLamp, _reverseLamp, _flashCount);
`else
  modport master (output _switch, _turnState, _gearState,
                  input  _leftLamp, _rightLamp, _reverseLamp, _flashCount);
  modport slave  (input  _switch, _turnState, _gearState,
                  output _leftLamp, _rightLamp, _reverseLamp, _flashCount);
`endif
endinterface

// File: rtl/turn_lamp_driver.sv
// Turn/hazard indicator blinker, reverse lamp and dashboard flash counter.
// Optional feature: define HAZARD_EN to add the _hazard input.
module turn_lamp_driver #(
  parameter  int unsigned BLINK_HALF = 25_000_000,
  localparam int unsigned CNT_W      = $clog2(BLINK_HALF)
) (
  input  logic                clock,
  input  logic                _reset,
  turn_lamp_driver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t             state_q, state_n;
  logic               side_q, side_n;   // 0 left, 1 right
  logic               haz_q, haz_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [7:0]         flash_q, flash_n;
  logic               left_q, right_q, rev_q;

  logic               hazard_req;
  logic               req_valid, req_side;
  logic               phase_end;
  state_t             adv_state;
  logic [CNT_W-1:0]   adv_cnt;
  logic [7:0]         adv_flash;

`ifdef HAZARD_EN
  assign hazard_req = bus._hazard;
`else
  assign hazard_req = 1'b0;
`endif

  // 01 and 11 are the only valid requests; bit 1 selects the side
  assign req_valid = bus._turnState[0];
  assign req_side  = bus._turnState[1];

  assign phase_end = (cnt_q == CNT_W'(BLINK_HALF - 1));

  always_comb begin
    adv_state = state_q;
    adv_cnt   = cnt_q + CNT_W'(1);
    adv_flash = flash_q;
    if (phase_end) begin
      adv_cnt = '0;
      if (state_q == ON) begin
        adv_state = OFF;
        if (flash_q != '1) adv_flash = flash_q + 8'd1;
      end else begin
        adv_state = ON;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    side_n  = side_q;
    haz_n   = haz_q;
    cnt_n   = cnt_q;
    flash_n = flash_q;
    if (!bus._switch) begin
      state_n = IDLE;
      side_n  = 1'b0;
      haz_n   = 1'b0;
      cnt_n   = '0;
      flash_n = '0;
    end else if (hazard_req) begin
      haz_n = 1'b1;
      if (!haz_q) begin
        state_n = ON;
        cnt_n   = '0;
        flash_n = '0;
      end else begin
        state_n = adv_state;
        cnt_n   = adv_cnt;
        flash_n = adv_flash;
      end
    end else if (haz_q) begin
      // Hazard released: keep phase timing with the requested side, or stop
      haz_n   = 1'b0;
      flash_n = '0;
      if (req_valid) begin
        side_n  = req_side;
        state_n = adv_state;
        cnt_n   = adv_cnt;
      end else begin
        state_n = IDLE;
        side_n  = 1'b0;
        cnt_n   = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_n = ON;
            side_n  = req_side;
            cnt_n   = '0;
            flash_n = '0;
          end
        end
        ON, OFF: begin
          if (!req_valid) begin
            state_n = IDLE;
            side_n  = 1'b0;
            cnt_n   = '0;
            flash_n = '0;
          end else if (req_side != side_q) begin
            state_n = ON;
            side_n  = req_side;
            cnt_n   = '0;
            flash_n = '0;
          end else begin
            state_n = adv_state;
            cnt_n   = adv_cnt;
            flash_n = adv_flash;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          flash_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge _reset) begin
    if (_reset) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      haz_q   <= 1'b0;
      cnt_q   <= '0;
      flash_q <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      side_q  <= side_n;
      haz_q   <= haz_n;
      cnt_q   <= cnt_n;
      flash_q <= flash_n;
      // Lamps registered from next state so they track the FSM with no extra latency
      left_q  <= (state_n == ON) && (haz_n || !side_n);
      right_q <= (state_n == ON) && (haz_n ||  side_n);
      rev_q   <= bus._switch && (bus._gearState == 2'b10);
    end
  end

  assign bus._leftLamp    = left_q;
  assign bus._rightLamp   = right_q;
  assign bus._reverseLamp = rev_q;
  assign bus._flashCount  = flash_q;

endmodule

// File: tb/tb_turn_lamp_driver.sv
// Directed bench for turn_lamp_driver with BLINK_HALF=4; hazard scenario under HAZARD_EN.
module tb_turn_lamp_driver;

  logic clock;
  logic _reset;
  int   n_cmp;
  int   n_bad;

  turn_lamp_driver_if bus ();

  turn_lamp_driver #(.BLINK_HALF(4)) dut (
    .clock  (clock),
    ._reset (_reset),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    bus._switch    = 1'b0;
    bus._turnState = 2'b00;
    tick();
    bus._switch    = 1'b1;
  endtask

  task automatic test_reset();
    _reset         = 1'b1;
    bus._switch    = 1'b0;
    bus._turnState = 2'b00;
    bus._gearState = 2'b00;
`ifdef HAZARD_EN
    bus._hazard    = 1'b0;
`endif
    #2;
    n_cmp++; if (bus._leftLamp !== 1'b0) begin n_bad++; $display("FAIL reset_left: got %b expected 0", bus._leftLamp); end
    n_cmp++; if (bus._rightLamp !== 1'b0) begin n_bad++; $display("FAIL reset_right: got %b expected 0", bus._rightLamp); end
    n_cmp++; if (bus._reverseLamp !== 1'b0) begin n_bad++; $display("FAIL reset_reverse: got %b expected 0", bus._reverseLamp); end
    n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL reset_flash: got %0d expected 0", bus._flashCount); end
    tick();
    tick();
    _reset = 1'b0;
  endtask

  task automatic test_left_blink();
    logic       exp_l;
    logic [7:0] exp_f;
    go_idle();
    bus._turnState = 2'b01;
    tick();
    for (int c = 1; c <= 12; c++) begin
      exp_l = (((c - 1) % 8) < 4);
      exp_f = (c < 5) ? 8'd0 : 8'd1;
      n_cmp++; if (bus._leftLamp !== exp_l) begin n_bad++; $display("FAIL blink_left c%0d: got %b expected %b", c, bus._leftLamp, exp_l); end
      n_cmp++; if (bus._rightLamp !== 1'b0) begin n_bad++; $display("FAIL blink_right c%0d: got %b expected 0", c, bus._rightLamp); end
      n_cmp++; if (bus._flashCount !== exp_f) begin n_bad++; $display("FAIL blink_flash c%0d: got %0d expected %0d", c, bus._flashCount, exp_f); end
      tick();
    end
  endtask

  task automatic test_drop_request();
    go_idle();
    bus._turnState = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus._rightLamp !== 1'b0) begin n_bad++; $display("FAIL drop_in_off: got %b expected 0", bus._rightLamp); end
    n_cmp++; if (bus._flashCount !== 8'd1) begin n_bad++; $display("FAIL drop_flash_pre: got %0d expected 1", bus._flashCount); end
    bus._turnState = 2'b00;
    tick();
    n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL drop_flash_clr: got %0d expected 0", bus._flashCount); end
    bus._turnState = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if ({bus._leftLamp, bus._rightLamp} !== 2'b00) begin n_bad++; $display("FAIL invalid_req i%0d: got %b expected 00", i, {bus._leftLamp, bus._rightLamp}); end
    end
    n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL invalid_flash: got %0d expected 0", bus._flashCount); end
  endtask

  task automatic test_side_switch();
    go_idle();
    bus._turnState = 2'b01;
    tick();
    tick();
    n_cmp++; if (bus._leftLamp !== 1'b1) begin n_bad++; $display("FAIL switch_pre_left: got %b expected 1", bus._leftLamp); end
    bus._turnState = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({bus._leftLamp, bus._rightLamp} !== 2'b01) begin n_bad++; $display("FAIL switch_on i%0d: got %b expected 01", i, {bus._leftLamp, bus._rightLamp}); end
      n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL switch_flash i%0d: got %0d expected 0", i, bus._flashCount); end
    end
    tick();
    n_cmp++; if ({bus._leftLamp, bus._rightLamp} !== 2'b00) begin n_bad++; $display("FAIL switch_off: got %b expected 00", {bus._leftLamp, bus._rightLamp}); end
    n_cmp++; if (bus._flashCount !== 8'd1) begin n_bad++; $display("FAIL switch_flash_end: got %0d expected 1", bus._flashCount); end
  endtask

  task automatic test_reverse_ignition();
    n_cmp++; if (bus._reverseLamp !== 1'b0) begin n_bad++; $display("FAIL reverse_pre: got %b expected 0", bus._reverseLamp); end
    bus._gearState = 2'b10;
    tick();
    n_cmp++; if (bus._reverseLamp !== 1'b1) begin n_bad++; $display("FAIL reverse_on: got %b expected 1", bus._reverseLamp); end
    bus._switch = 1'b0;
    tick();
    n_cmp++; if ({bus._leftLamp, bus._rightLamp, bus._reverseLamp} !== 3'b000) begin n_bad++; $display("FAIL ignition_off: got %b expected 000", {bus._leftLamp, bus._rightLamp, bus._reverseLamp}); end
    n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL ignition_flash: got %0d expected 0", bus._flashCount); end
    bus._gearState = 2'b00;
  endtask

  task automatic test_async_reset();
    go_idle();
    bus._turnState = 2'b01;
    tick();
    tick();
    #1;
    _reset = 1'b1;
    #1;
    n_cmp++; if ({bus._leftLamp, bus._rightLamp, bus._reverseLamp} !== 3'b000) begin n_bad++; $display("FAIL async_lamps: got %b expected 000", {bus._leftLamp, bus._rightLamp, bus._reverseLamp}); end
    n_cmp++; if (bus._flashCount !== 8'd0) begin n_bad++; $display("FAIL async_flash: got %0d expected 0", bus._flashCount); end
    tick();
    _reset = 1'b0;
    #1;
    n_cmp++; if (bus._leftLamp !== 1'b0) begin n_bad++; $display("FAIL release_pre: got %b expected 0", bus._leftLamp); end
    tick();
    n_cmp++; if (bus._leftLamp !== 1'b1) begin n_bad++; $display("FAIL release_left: got %b expected 1", bus._leftLamp); end
  endtask

  task automatic test_saturate();
    go_idle();
    bus._turnState = 2'b01;
    tick();
    for (int i = 0; i < 4 + 8 * 253; i++) tick();
    n_cmp++; if (bus._flashCount !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d expected 254", bus._flashCount); end
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (bus._flashCount !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d expected 255", bus._flashCount); end
    for (int i = 0; i < 8 * 50; i++) tick();
    n_cmp++; if (bus._flashCount !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d expected 255", bus._flashCount); end
  endtask

`ifdef HAZARD_EN
  task automatic test_hazard();
    logic exp_on;
    go_idle();
    bus._turnState = 2'b01;
    bus._hazard    = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      exp_on = (c <= 4);
      n_cmp++; if ({bus._leftLamp, bus._rightLamp} !== {exp_on, exp_on}) begin n_bad++; $display("FAIL hazard c%0d: got %b expected %b%b", c, {bus._leftLamp, bus._rightLamp}, exp_on, exp_on); end
      tick();
    end
    n_cmp++; if (bus._flashCount !== 8'd1) begin n_bad++; $display("FAIL hazard_flash: got %0d expected 1", bus._flashCount); end
    bus._hazard = 1'b0;
    for (int c = 10; c <= 13; c++) begin
      tick();
      exp_on = (c <= 12);
      n_cmp++; if ({bus._leftLamp, bus._rightLamp} !== {exp_on, 1'b0}) begin n_bad++; $display("FAIL hazard_exit c%0d: got %b expected %b0", c, {bus._leftLamp, bus._rightLamp}, exp_on); end
    end
    n_cmp++; if (bus._flashCount !== 8'd1) begin n_bad++; $display("FAIL hazard_exit_flash: got %0d expected 1", bus._flashCount); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_left_blink();
    test_drop_request();
    test_side_switch();
    test_reverse_ignition();
    test_async_reset();
    test_saturate();
`ifdef HAZARD_EN
    test_hazard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
